// File: rtl/branch_cmp_pkg.sv
// Shared types and default sizes for the serial branch comparator.
package branch_cmp_pkg;

  localparam int BRANCH_XLEN    = 32;
  localparam int BRANCH_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

endpackage

// File: rtl/branch_cmp_serial_digit_cmp.sv
// Combinational equal / unsigned-less-than compare of one operand digit pair.
module digit_cmp #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  output logic               eq_o,
  output logic               lt_u_o
);

  assign eq_o   = (a_i == b_i);
  assign lt_u_o = (a_i < b_i);

endmodule

// File: rtl/branch_cmp_serial.sv
// Serial MSB-first operand comparator producing zero / signed-lt / unsigned-lt flags.
// Define BRANCH_CMP_EARLY_EXIT_EN to finish as soon as the first differing digit is seen.
module branch_cmp_serial
  import branch_cmp_pkg::*;
#(
  parameter int XLEN    = BRANCH_XLEN,
  parameter int DIGIT_W = BRANCH_DIGIT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic            zero,
  output logic            less_than,
  output logic            less_than_u
);

  localparam int NDIG  = XLEN / DIGIT_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (XLEN % DIGIT_W != 0) begin : g_bad_width
      $error("branch_cmp_serial: XLEN must be a multiple of DIGIT_W");
    end
  endgenerate

  cmp_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic diff_q, diff_d, ltuTrk_q, ltuTrk_d;
  logic zero_q, zero_d, lt_q, lt_d, ltu_q, ltu_d;

  logic [NDIG-1:0][DIGIT_W-1:0] aDigits, bDigits;
  logic digEq, digLtu;
  logic diffNow, ltuNow, exitRun;

  assign aDigits = a_q;
  assign bDigits = b_q;

  digit_cmp #(.DIGIT_W(DIGIT_W)) u_digit_cmp (
    .a_i   (aDigits[idx_q]),
    .b_i   (bDigits[idx_q]),
    .eq_o  (digEq),
    .lt_u_o(digLtu)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= 1'b0;
      ltuTrk_q <= 1'b0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      ltuTrk_q <= ltuTrk_d;
      zero_q   <= zero_d;
      lt_q     <= lt_d;
      ltu_q    <= ltu_d;
    end
  end

  // Once a differing digit is recorded, lower digits can no longer change the decision.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    ltuTrk_d = ltuTrk_q;
    zero_d   = zero_q;
    lt_d     = lt_q;
    ltu_d    = ltu_q;
    diffNow  = diff_q | ~digEq;
    ltuNow   = diff_q ? ltuTrk_q : digLtu;
    exitRun  = 1'b0;

    case (state_q)
      RUN: begin
        diff_d   = diffNow;
        ltuTrk_d = ltuNow;
        idx_d    = idx_q - IDX_W'(1);
`ifdef BRANCH_CMP_EARLY_EXIT_EN
        exitRun  = (idx_q == '0) | diffNow;
`else
        exitRun  = (idx_q == '0);
`endif
        if (exitRun) begin
          state_d = DONE;
          zero_d  = ~diffNow;
          ltu_d   = diffNow & ltuNow;
          lt_d    = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? a_q[XLEN-1] : (diffNow & ltuNow);
        end
      end
      default: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          a_d      = rs1;
          b_d      = rs2;
          diff_d   = 1'b0;
          ltuTrk_d = 1'b0;
          idx_d    = IDX_W'(NDIG - 1);
          state_d  = RUN;
        end
      end
    endcase
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign zero        = zero_q;
  assign less_than   = lt_q;
  assign less_than_u = ltu_q;

endmodule

// File: doc/branch_cmp_serial.md
# branch_cmp_serial

Multi-cycle operand comparator that produces the `zero`, `less_than` and `less_than_u` flags consumed by branch-decision logic. It scans `rs1`/`rs2` MSB-first, one digit per cycle, and reports completion with a one-cycle `done` pulse. It sits between the register-file read stage and the branch-decision logic, replacing the full-width ALU subtract for compare-only branch resolution in area-constrained builds.

## Interface
Parameters:
- `XLEN`, 32: operand width.
- `DIGIT_W`, 4: bits compared per cycle. `XLEN % DIGIT_W` must be 0; any other value is an elaboration error. `NDIG = XLEN/DIGIT_W`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `rs1`  in  XLEN  operand A, captured on an accepted `start`.
- `rs2`  in  XLEN  operand B, captured on an accepted `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; flags are valid from this cycle onward.
- `zero`  out  1  rs1 == rs2.
- `less_than`  out  1  rs1 < rs2, signed.
- `less_than_u`  out  1  rs1 < rs2, unsigned.

## Operation
- States:
  - IDLE: `start`=1 latches operands, clears the decision tracker, sets digit index `idx`=NDIG-1, goes to RUN.
  - RUN: compares digit `idx`. After `idx`=0, goes to DONE. `idx` decrements by 1 each cycle.
  - DONE: held for one cycle, `done`=1. The next state is IDLE, or RUN if `start`=1 in this cycle.
- Unsigned decision: the first differing digit (MSB-first) sets `ltu = (a_dig < b_dig)`. Later digits are ignored once a difference is recorded.
- Signed decision: if the operand sign bits differ, `lt = rs1[XLEN-1]`. Otherwise `lt = ltu`.
- No differing digit: `zero`=1, `less_than`=0, `less_than_u`=0.
- Flags are written only on the RUN→DONE transition and hold until the next RUN→DONE transition.
- `start` while `busy`=1 is ignored, with no queueing. Operands are not re-sampled after capture.
- Reset values: state IDLE; `busy`, `done`, `zero`, `less_than`, `less_than_u` all 0.
- Reset during RUN aborts the compare. No `done` is produced and the flags return to 0.

## Timing
- An accepted `start` in cycle 0 puts RUN in cycles 1..NDIG and `done` in cycle NDIG+1. With the defaults, `done` is in cycle 9.
- `busy` rises in cycle 1 and falls in the `done` cycle.
- Back-to-back throughput: `start` in the `done` cycle is accepted, giving one result every NDIG+1 cycles.
- `done` is never high for two consecutive cycles.

## Configuration
- `BRANCH_CMP_EARLY_EXIT_EN` defined:
  - RUN exits to DONE in the cycle after the first differing digit is found.
  - A difference at digit position j (0 = most-significant digit) gives `done` in cycle j+2.
  - Equal operands still take NDIG+1 cycles.
- Undefined: fixed latency of NDIG+1 cycles for every operand pair.
- Flag values are identical in both builds.

## Structure
- Package `branch_cmp_pkg` holds:
  - the state enum type `cmp_state_t` with IDLE/RUN/DONE;
  - the default constants `BRANCH_XLEN`=32 and `BRANCH_DIGIT_W`=4.
- Sub-module `digit_cmp`: combinational, width `DIGIT_W`, outputs `eq` and `lt_u` for one digit pair. The top instantiates it once on the muxed digit `idx`.
- The top contains the FSM, the `idx` counter, the operand registers, the sticky difference/`ltu` tracker and the output flag registers.

## Test plan
- Equal operands: `rs1`=`rs2`=0x12345678 → `done` in cycle 9, `zero`=1, `less_than`=0, `less_than_u`=0 (both builds).
- Sign split: `rs1`=0xFFFFFFFF, `rs2`=0x00000001 → `zero`=0, `less_than`=1, `less_than_u`=0. `done` in cycle 2 with `BRANCH_CMP_EARLY_EXIT_EN`, cycle 9 without.
- LSB-digit difference: `rs1`=0x00000005, `rs2`=0x00000007 → `less_than`=1, `less_than_u`=1, `done` in cycle 9 in both builds.
- Ignored start: accepted `start` (0x10 vs 0x20) in cycle 0, then a second `start` (0x30 vs 0x01) in cycle 3 → exactly one `done` in cycle 9, with `less_than_u`=1 from the first pair.
- Reset mid-op: `start` in cycle 0, `rst`=1 in cycle 4 → from cycle 5 on, `busy`=0 and all flags 0; `done` never asserted.
- Back-to-back: a second `start` (0x80000000 vs 0x7FFFFFFF) in the `done` cycle of the first compare → accepted, second `done` 9 cycles later with `less_than`=1, `less_than_u`=0.
